// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment scan driver.
// Segment order is seg[6]=a ... seg[0]=g, active-high.
package seg7_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h00;

    // Entry n holds the active-high abcdefg pattern for hex digit n.
    localparam seg_t [15:0] HEX_TABLE = {
        7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
        7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-high segment pattern.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output seg_t       seg_o
);

    assign seg_o = HEX_TABLE[nibble_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed multi-digit 7-segment driver with double-buffered content
// committed only at scan-frame boundaries.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned DEAD_CYCLES    = 16,
    parameter int unsigned BLINK_FRAMES   = 64,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output seg_t                    seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    pending,
    output logic                    frame_tick
);

    localparam int unsigned PW = (SCAN_DIV > 1)     ? $clog2(SCAN_DIV)     : 1;
    localparam int unsigned IW = (NUM_DIGITS > 1)   ? $clog2(NUM_DIGITS)   : 1;
    localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int unsigned DW = 4 * NUM_DIGITS;

    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [FW-1:0]         frm_q, frm_d;
    logic                  phase_q, phase_d;
    logic [DW-1:0]         sh_data_q, sh_data_d, act_data_q, act_data_d;
    logic [NUM_DIGITS-1:0] sh_blank_q, sh_blank_d, act_blank_q, act_blank_d;
    logic [NUM_DIGITS-1:0] sh_blink_q, sh_blink_d, act_blink_q, act_blink_d;
    logic [NUM_DIGITS-1:0] sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
    logic                  pending_q, pending_d;

    seg_t                  seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  tick_q;

    logic                  frame_end;
    logic [3:0]            nibble;
    seg_t                  seg_hex;
    seg_t                  seg_hi;
    logic                  dp_hi;
    logic                  dark;
    logic [NUM_DIGITS-1:0] an_hi;

    assign frame_end = (presc_q == PW'(SCAN_DIV - 1)) && (idx_q == IW'(NUM_DIGITS - 1));

    // Scan counters, shadow capture and frame-boundary commit.
    always_comb begin
        presc_d     = presc_q + PW'(1);
        idx_d       = idx_q;
        frm_d       = frm_q;
        phase_d     = phase_q;
        sh_data_d   = sh_data_q;
        sh_blank_d  = sh_blank_q;
        sh_blink_d  = sh_blink_q;
        sh_dp_d     = sh_dp_q;
        act_data_d  = act_data_q;
        act_blank_d = act_blank_q;
        act_blink_d = act_blink_q;
        act_dp_d    = act_dp_q;
        pending_d   = pending_q;

        if (presc_q == PW'(SCAN_DIV - 1)) begin
            presc_d = '0;
            idx_d   = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end

        if (load) begin
            sh_data_d  = data_in;
            sh_blank_d = blank_mask;
            sh_blink_d = blink_mask;
            sh_dp_d    = dp_in;
            pending_d  = 1'b1;
        end

        if (frame_end) begin
            // A load in this very cycle bypasses the shadow straight into active.
            if (pending_d) begin
                act_data_d  = sh_data_d;
                act_blank_d = sh_blank_d;
                act_blink_d = sh_blink_d;
                act_dp_d    = sh_dp_d;
            end
            pending_d = 1'b0;
            if (frm_q == FW'(BLINK_FRAMES - 1)) begin
                frm_d   = '0;
                phase_d = ~phase_q;
            end else begin
                frm_d = frm_q + FW'(1);
            end
        end
    end

    seg7_hex_decode u_hex_decode (
        .nibble_i (nibble),
        .seg_o    (seg_hex)
    );

    // Pin values for the digit currently being scanned, polarity applied last.
    always_comb begin
        nibble = act_data_q[{idx_q, 2'b00} +: 4];
        dark   = act_blank_q[idx_q] | (act_blink_q[idx_q] & phase_q);
        seg_hi = dark ? SEG_BLANK : seg_hex;
        dp_hi  = ~dark & act_dp_q[idx_q];
        an_hi  = (presc_q < PW'(DEAD_CYCLES)) ? '0 : (NUM_DIGITS'(1) << idx_q);
        seg_d  = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
        dp_d   = SEG_ACTIVE_LOW ? ~dp_hi : dp_hi;
        an_d   = AN_ACTIVE_LOW ? ~an_hi : an_hi;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q     <= '0;
            idx_q       <= '0;
            frm_q       <= '0;
            phase_q     <= 1'b0;
            sh_data_q   <= '0;
            sh_blank_q  <= '1;
            sh_blink_q  <= '0;
            sh_dp_q     <= '0;
            act_data_q  <= '0;
            act_blank_q <= '1;
            act_blink_q <= '0;
            act_dp_q    <= '0;
            pending_q   <= 1'b0;
            seg_q       <= {7{SEG_ACTIVE_LOW}};
            dp_q        <= SEG_ACTIVE_LOW;
            an_q        <= {NUM_DIGITS{AN_ACTIVE_LOW}};
            tick_q      <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            frm_q       <= frm_d;
            phase_q     <= phase_d;
            sh_data_q   <= sh_data_d;
            sh_blank_q  <= sh_blank_d;
            sh_blink_q  <= sh_blink_d;
            sh_dp_q     <= sh_dp_d;
            act_data_q  <= act_data_d;
            act_blank_q <= act_blank_d;
            act_blink_q <= act_blink_d;
            act_dp_q    <= act_dp_d;
            pending_q   <= pending_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            an_q        <= an_d;
            tick_q      <= frame_end;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign pending    = pending_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: directed and random loads checked cycle by cycle
// against a time-based behavioural model of the display.
module tb_seg7_scan_driver;

    localparam int unsigned N   = 4;
    localparam int unsigned S   = 8;
    localparam int unsigned DC  = 2;
    localparam int unsigned BF  = 2;
    localparam int unsigned FRM = S * N;

    logic          clk;
    logic          rst;
    logic          load;
    logic [15:0]   data_in;
    logic [3:0]    blank_mask;
    logic [3:0]    blink_mask;
    logic [3:0]    dp_in;
    logic [6:0]    seg;
    logic          dp;
    logic [3:0]    an;
    logic          pending;
    logic          frame_tick;

    int unsigned   n_checks;
    int unsigned   n_errors;

    logic [6:0]    hex_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                   7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    // Model state: t counts clock edges since reset release.
    int unsigned   t;
    logic [15:0]   m_sh_data, m_act_data;
    logic [3:0]    m_sh_blank, m_sh_blink, m_sh_dp;
    logic [3:0]    m_act_blank, m_act_blink, m_act_dp;
    bit            m_pend;

    seg7_scan_driver #(
        .NUM_DIGITS     (N),
        .SCAN_DIV       (S),
        .DEAD_CYCLES    (DC),
        .BLINK_FRAMES   (BF),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .data_in    (data_in),
        .blank_mask (blank_mask),
        .blink_mask (blink_mask),
        .dp_in      (dp_in),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .pending    (pending),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
        end
    endtask

    task automatic model_reset();
        t           = 0;
        m_sh_data   = '0;
        m_act_data  = '0;
        m_sh_blank  = '1;
        m_act_blank = '1;
        m_sh_blink  = '0;
        m_act_blink = '0;
        m_sh_dp     = '0;
        m_act_dp    = '0;
        m_pend      = 1'b0;
    endtask

    // Predict the pins after the coming edge, advance the model, then compare.
    task automatic step();
        int unsigned presc, dig, frame;
        bit          ph, bnd, dark;
        logic [6:0]  e_seg;
        logic        e_dp, e_ft;
        logic [3:0]  e_an;
        if (rst) begin
            e_seg = 7'h7F;
            e_dp  = 1'b1;
            e_an  = 4'hF;
            e_ft  = 1'b0;
            model_reset();
        end else begin
            presc = t % S;
            dig   = (t / S) % N;
            frame = t / FRM;
            ph    = ((frame / BF) % 2) == 1;
            bnd   = (t % FRM) == FRM - 1;
            dark  = m_act_blank[dig] || (m_act_blink[dig] && ph);
            e_seg = dark ? 7'h7F : ~hex_tab[m_act_data[4*dig +: 4]];
            e_dp  = dark ? 1'b1 : ~m_act_dp[dig];
            e_an  = (presc < DC) ? 4'hF : 4'(~(4'b0001 << dig));
            e_ft  = bnd;
            if (load) begin
                m_sh_data  = data_in;
                m_sh_blank = blank_mask;
                m_sh_blink = blink_mask;
                m_sh_dp    = dp_in;
                m_pend     = 1'b1;
            end
            if (bnd) begin
                if (m_pend) begin
                    m_act_data  = m_sh_data;
                    m_act_blank = m_sh_blank;
                    m_act_blink = m_sh_blink;
                    m_act_dp    = m_sh_dp;
                end
                m_pend = 1'b0;
            end
            t++;
        end
        @(posedge clk);
        #1;
        check_val("seg", 32'(seg), 32'(e_seg));
        check_val("dp", 32'(dp), 32'(e_dp));
        check_val("an", 32'(an), 32'(e_an));
        check_val("frame_tick", 32'(frame_tick), 32'(e_ft));
        check_val("pending", 32'(pending), 32'(m_pend));
    endtask

    task automatic run(input int unsigned cycles);
        for (int i = 0; i < int'(cycles); i++) step();
    endtask

    task automatic run_until(input int unsigned pos);
        for (int i = 0; i < 2 * int'(FRM) && (t % FRM) != pos; i++) step();
        check_val("sync", 32'(t % FRM), 32'(pos));
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] bl, input logic [3:0] bk,
                           input logic [3:0] p);
        data_in    = d;
        blank_mask = bl;
        blink_mask = bk;
        dp_in      = p;
        load       = 1'b1;
        step();
        load       = 1'b0;
    endtask

    initial begin
        clk        = 1'b0;
        rst        = 1'b1;
        load       = 1'b0;
        data_in    = '0;
        blank_mask = '0;
        blink_mask = '0;
        dp_in      = '0;
        n_checks   = 0;
        n_errors   = 0;
        model_reset();

        // Reset hold and idle run past the first frame tick.
        run(3);
        rst = 1'b0;
        run(40);

        // Basic content with a decimal point on digit 2.
        do_load(16'h3210, 4'b0000, 4'b0000, 4'b0100);
        run(2 * FRM);

        // Two loads in one frame; last one wins.
        run_until(3);
        do_load(16'hAAAA, 4'b0000, 4'b0000, 4'b0000);
        run(5);
        do_load(16'hBEEF, 4'b0000, 4'b0000, 4'b0000);
        run(2 * FRM);

        // Load exactly on the frame-boundary cycle.
        run_until(FRM - 1);
        do_load(16'h0F0F, 4'b0000, 4'b0000, 4'b0000);
        run(FRM + 4);

        // Blink digit 0 across several blink periods.
        do_load(16'h8888, 4'b0000, 4'b0001, 4'b0000);
        run(10 * FRM);

        // Random loads, including random boundary hits.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0)
                do_load(16'($urandom()), 4'($urandom()), 4'($urandom()), 4'($urandom()));
            else
                step();
        end

        // Reset mid-slot of digit 2 with a pending shadow.
        run_until(5);
        do_load(16'h1234, 4'b0000, 4'b0000, 4'b1111);
        run_until(2 * S + 4);
        check_val("pend_before_rst", 32'(pending), 32'(1));
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        run(2 * FRM);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
